read_master: RTL and testbench

- AXI4-Full read-side DMA engine; fetches `i_total_len` bytes from `i_src_addr` as INCR bursts.
- Pushes every received beat into the shared data FIFO that `Write_Master` drains.
- Directly upstream of the FIFO/Write_Master pair; started by the same DMA control logic.
- Holds one outstanding burst at a time. It never issues AR unless the FIFO can absorb the whole burst.

---
 rtl/dma_pkg.sv | 20 ++
 rtl/burst_calc.sv | 34 +++
 rtl/read_master.sv | 136 +++++++++++++
 tb/tb_read_master.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared DMA definitions: AXI encodings, page size and read FSM states.
// Imported by the read/write masters and their helpers.
package dma_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam int unsigned BOUNDARY_4K = 4096;

  typedef enum logic [2:0] {
    RD_IDLE,
    RD_CALC,
    RD_WAIT_SPACE,
    RD_AR,
    RD_RDATA,
    RD_DONE
  } rd_state_e;

endpackage

// File: rtl/burst_calc.sv
// Burst sizing: min of remaining beats, max burst length and beats
// left before the next 4 KB page boundary.
module burst_calc
  import dma_pkg::*;
#(
  parameter int unsigned MAX_BURST = 16
) (
  input  logic [29:0] rem_beats,
  input  logic [11:0] addr_lo,
  output logic [8:0]  beats
);

  logic [12:0] page_bytes;
  logic [10:0] page_beats;
  logic [29:0] m;
  logic        unused_bits;

  assign page_bytes = 13'(BOUNDARY_4K) - {1'b0, addr_lo};
  assign page_beats = page_bytes[12:2];

  always_comb begin
    m = rem_beats;
    if (m > 30'(MAX_BURST))
      m = 30'(MAX_BURST);
    if (m > 30'(page_beats))
      m = 30'(page_beats);
  end

  assign beats = m[8:0];

  // Upper bits are always zero once clipped to MAX_BURST (<= 256).
  assign unused_bits = ^{page_bytes[1:0], m[29:9]};

endmodule

// File: rtl/read_master.sv
// AXI4 read-side DMA engine: INCR bursts from source into the data FIFO.
// One burst in flight; AR is only issued once the FIFO can hold it all.
module read_master
  import dma_pkg::*;
#(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_MAX_BURST_LEN    = 16,
  parameter int unsigned C_FIFO_DEPTH       = 64,
  parameter int unsigned C_FIFO_CNT_W       = 7
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_src_addr,
  input  logic [31:0]                   i_total_len,
  output logic                          o_read_done,
  output logic                          o_read_error,
  input  logic [C_FIFO_CNT_W-1:0]       i_fifo_count,
  output logic                          o_fifo_wr_en,
  output logic [C_M_AXI_DATA_WIDTH-1:0] o_fifo_wr_data,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  rd_state_e state, state_nx;

  logic [C_M_AXI_ADDR_WIDTH-1:0] addr;
  logic [29:0] rem_beats;
  logic [29:0] rem_after;
  logic [8:0]  burst_beats;
  logic [8:0]  calc_beats;
  logic [8:0]  beat_cnt;
  logic        read_error;
  logic        beat;
  logic        last_beat;
  logic [31:0] cnt_ext;
  logic [31:0] free_words;
  logic        space_ok;
  logic        unused_len;

  assign unused_len = ^i_total_len[1:0];

  burst_calc #(
    .MAX_BURST (C_MAX_BURST_LEN)
  ) u_burst_calc (
    .rem_beats (rem_beats),
    .addr_lo   (addr[11:0]),
    .beats     (calc_beats)
  );

  assign beat      = m_axi_rvalid && (state == RD_RDATA);
  assign last_beat = (beat_cnt == burst_beats - 9'd1);
  assign rem_after = rem_beats - 30'(burst_beats);

  // Guard against a count above depth so the subtraction cannot wrap.
  assign cnt_ext    = 32'(i_fifo_count);
  assign free_words = 32'(C_FIFO_DEPTH) - cnt_ext;
  assign space_ok   = (cnt_ext <= 32'(C_FIFO_DEPTH)) &&
                      (free_words >= 32'(burst_beats));

  always_comb begin
    state_nx = state;
    unique case (state)
      RD_IDLE:
        if (i_start)
          state_nx = (i_total_len[31:2] == 30'd0) ? RD_DONE : RD_CALC;
      RD_CALC:       state_nx = RD_WAIT_SPACE;
      RD_WAIT_SPACE: if (space_ok) state_nx = RD_AR;
      RD_AR:         if (m_axi_arready) state_nx = RD_RDATA;
      RD_RDATA:
        if (beat && last_beat)
          state_nx = (rem_after == 30'd0) ? RD_DONE : RD_CALC;
      RD_DONE:       state_nx = RD_IDLE;
      default:       state_nx = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RD_IDLE;
      addr        <= '0;
      rem_beats   <= '0;
      burst_beats <= '0;
      beat_cnt    <= '0;
      read_error  <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        RD_IDLE:
          if (i_start) begin
            addr       <= i_src_addr;
            rem_beats  <= i_total_len[31:2];
            read_error <= 1'b0;
          end
        RD_CALC: begin
          burst_beats <= calc_beats;
          beat_cnt    <= '0;
        end
        RD_RDATA:
          if (beat) begin
            beat_cnt <= beat_cnt + 9'd1;
            // Beat counter ends the burst; rlast is only cross-checked.
            if (m_axi_rresp != RESP_OKAY || m_axi_rlast != last_beat)
              read_error <= 1'b1;
            if (last_beat) begin
              addr      <= addr + C_M_AXI_ADDR_WIDTH'({burst_beats, 2'b00});
              rem_beats <= rem_after;
            end
          end
        default: ;
      endcase
    end
  end

  assign m_axi_arvalid  = (state == RD_AR);
  assign m_axi_araddr   = m_axi_arvalid ? addr : '0;
  assign m_axi_arlen    = m_axi_arvalid ? 8'(burst_beats - 9'd1) : 8'd0;
  assign m_axi_arsize   = SIZE_4B;
  assign m_axi_arburst  = BURST_INCR;
  assign m_axi_rready   = (state == RD_RDATA);
  assign o_fifo_wr_en   = beat;
  assign o_fifo_wr_data = beat ? m_axi_rdata : '0;
  assign o_read_done    = (state == RD_DONE);
  assign o_read_error   = read_error;

endmodule

// File: tb/tb_read_master.sv
// Directed bench for read_master with an inline AXI read slave.
// Data for each beat is derived from its expected byte address.
module tb_read_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [31:0] i_src_addr;
  logic [31:0] i_total_len;
  logic        o_read_done;
  logic        o_read_error;
  logic [6:0]  i_fifo_count;
  logic        o_fifo_wr_en;
  logic [31:0] o_fifo_wr_data;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  read_master dut (
    .clk            (clk),
    .reset          (rst),
    .i_start        (i_start),
    .i_src_addr     (i_src_addr),
    .i_total_len    (i_total_len),
    .o_read_done    (o_read_done),
    .o_read_error   (o_read_error),
    .i_fifo_count   (i_fifo_count),
    .o_fifo_wr_en   (o_fifo_wr_en),
    .o_fifo_wr_data (o_fifo_wr_data),
    .m_axi_araddr   (m_axi_araddr),
    .m_axi_arlen    (m_axi_arlen),
    .m_axi_arsize   (m_axi_arsize),
    .m_axi_arburst  (m_axi_arburst),
    .m_axi_arvalid  (m_axi_arvalid),
    .m_axi_arready  (m_axi_arready),
    .m_axi_rdata    (m_axi_rdata),
    .m_axi_rresp    (m_axi_rresp),
    .m_axi_rlast    (m_axi_rlast),
    .m_axi_rvalid   (m_axi_rvalid),
    .m_axi_rready   (m_axi_rready)
  );

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic start(input logic [31:0] a, input logic [31:0] len);
    @(negedge clk);
    i_start     = 1'b1;
    i_src_addr  = a;
    i_total_len = len;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // ea/nb: expected burst; eb: beat given SLVERR; lb: beat carrying rlast;
  // ab: beat on which reset is asserted (-1 for none).
  task automatic serve_burst(input logic [31:0] ea, input int nb,
                             input int eb, input int lb, input int ab);
    int k;
    logic [31:0] exp;
    k = 0;
    #1;
    while (!m_axi_arvalid && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    checks++;
    if (!m_axi_arvalid) begin
      errors++;
      $display("FAIL ar_timeout: arvalid=%b required 1", m_axi_arvalid);
      return;
    end
    checks++;
    if (m_axi_araddr !== ea) begin
      errors++;
      $display("FAIL araddr: got %h required %h", m_axi_araddr, ea);
    end
    checks++;
    if (m_axi_arlen !== 8'(nb - 1)) begin
      errors++;
      $display("FAIL arlen: got %0d required %0d", m_axi_arlen, nb - 1);
    end
    m_axi_arready = 1'b1;
    @(negedge clk);
    m_axi_arready = 1'b0;
    for (int i = 0; i < nb; i++) begin
      exp          = pat(ea + 32'(4 * i));
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = exp;
      m_axi_rresp  = (i == eb) ? 2'b10 : 2'b00;
      m_axi_rlast  = (i == lb);
      #1;
      checks++;
      if (o_fifo_wr_en !== 1'b1 || o_fifo_wr_data !== exp ||
          m_axi_rready !== 1'b1 || m_axi_arvalid !== 1'b0) begin
        errors++;
        $display("FAIL push[%0d]: wr_en=%b data=%h rready=%b arvalid=%b required 1 %h 1 0",
                 i, o_fifo_wr_en, o_fifo_wr_data, m_axi_rready,
                 m_axi_arvalid, exp);
      end
      if (i == ab) begin
        rst = 1'b1;
        #1;
        checks++;
        if (m_axi_arvalid !== 1'b0 || m_axi_rready !== 1'b0 ||
            o_fifo_wr_en !== 1'b0) begin
          errors++;
          $display("FAIL reset_mid: arvalid=%b rready=%b wr_en=%b required 0 0 0",
                   m_axi_arvalid, m_axi_rready, o_fifo_wr_en);
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        m_axi_rresp  = 2'b00;
        return;
      end
      @(negedge clk);
    end
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    m_axi_rresp  = 2'b00;
  endtask

  task automatic wait_done(input logic exp_err);
    int k;
    k = 0;
    #1;
    while (!o_read_done && k < 40) begin
      @(negedge clk);
      #1;
      k++;
    end
    checks++;
    if (o_read_done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: done=%b required 1", o_read_done);
    end
    checks++;
    if (o_read_error !== exp_err) begin
      errors++;
      $display("FAIL read_error: got %b required %b", o_read_error, exp_err);
    end
    @(negedge clk);
    #1;
    checks++;
    if (o_read_done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b required 0 one cycle later", o_read_done);
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (m_axi_arvalid !== 1'b0 || m_axi_rready !== 1'b0 ||
        o_fifo_wr_en !== 1'b0 || o_read_done !== 1'b0 ||
        o_read_error !== 1'b0 || m_axi_araddr !== 32'd0 ||
        m_axi_arlen !== 8'd0 || o_fifo_wr_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: arv=%b rr=%b we=%b dn=%b er=%b aa=%h al=%h wd=%h required all 0",
               m_axi_arvalid, m_axi_rready, o_fifo_wr_en, o_read_done,
               o_read_error, m_axi_araddr, m_axi_arlen, o_fifo_wr_data);
    end
    checks++;
    if (m_axi_arsize !== 3'b010 || m_axi_arburst !== 2'b01) begin
      errors++;
      $display("FAIL reset_consts: arsize=%b arburst=%b required 010 01",
               m_axi_arsize, m_axi_arburst);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single;
    start(32'hC000_0000, 32'd64);
    #1;
    checks++;
    if (m_axi_arvalid !== 1'b0) begin
      errors++;
      $display("FAIL latency_calc: arvalid=%b required 0", m_axi_arvalid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (m_axi_arvalid !== 1'b0) begin
      errors++;
      $display("FAIL latency_wait: arvalid=%b required 0", m_axi_arvalid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (m_axi_arvalid !== 1'b1) begin
      errors++;
      $display("FAIL latency_ar: arvalid=%b required 1", m_axi_arvalid);
    end
    serve_burst(32'hC000_0000, 16, -1, 15, -1);
    wait_done(1'b0);
  endtask

  task automatic test_two_bursts;
    start(32'hC000_1000, 32'd128);
    serve_burst(32'hC000_1000, 16, -1, 15, -1);
    serve_burst(32'hC000_1040, 16, -1, 15, -1);
    wait_done(1'b0);
  endtask

  task automatic test_4k_boundary;
    start(32'hC000_0FF0, 32'd32);
    serve_burst(32'hC000_0FF0, 4, -1, 3, -1);
    serve_burst(32'hC000_1000, 4, -1, 3, -1);
    wait_done(1'b0);
  endtask

  task automatic test_fifo_space;
    int k;
    i_fifo_count = 7'd56;
    start(32'hC000_2000, 32'd64);
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (m_axi_arvalid !== 1'b0) begin
        errors++;
        $display("FAIL space_hold[%0d]: arvalid=%b required 0", i, m_axi_arvalid);
      end
      @(negedge clk);
    end
    i_fifo_count = 7'd48;
    k = 0;
    @(negedge clk);
    #1;
    while (!m_axi_arvalid && k < 1) begin
      @(negedge clk);
      #1;
      k++;
    end
    checks++;
    if (m_axi_arvalid !== 1'b1) begin
      errors++;
      $display("FAIL space_release: arvalid=%b required 1 within 2 cycles",
               m_axi_arvalid);
    end
    serve_burst(32'hC000_2000, 16, -1, 15, -1);
    wait_done(1'b0);
    i_fifo_count = 7'd0;
  endtask

  task automatic test_rresp_error;
    start(32'hC000_3000, 32'd64);
    serve_burst(32'hC000_3000, 16, 4, 15, -1);
    wait_done(1'b1);
    start(32'hC000_4000, 32'd16);
    #1;
    checks++;
    if (o_read_error !== 1'b0) begin
      errors++;
      $display("FAIL error_clear: read_error=%b required 0", o_read_error);
    end
    serve_burst(32'hC000_4000, 4, -1, 3, -1);
    wait_done(1'b0);
  endtask

  task automatic test_rlast_early;
    start(32'hC000_5000, 32'd16);
    serve_burst(32'hC000_5000, 4, -1, 1, -1);
    wait_done(1'b1);
  endtask

  task automatic test_reset_mid;
    start(32'hC000_6000, 32'd64);
    serve_burst(32'hC000_6000, 16, -1, 15, 6);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (o_read_done !== 1'b0 || m_axi_arvalid !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: done=%b arvalid=%b required 0 0",
                 i, o_read_done, m_axi_arvalid);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    start(32'hC000_7000, 32'd16);
    serve_burst(32'hC000_7000, 4, -1, 3, -1);
    wait_done(1'b0);
  endtask

  task automatic test_zero_len;
    start(32'hC000_8000, 32'd3);
    #1;
    checks++;
    if (o_read_done !== 1'b1 || m_axi_arvalid !== 1'b0) begin
      errors++;
      $display("FAIL zero_len: done=%b arvalid=%b required 1 0",
               o_read_done, m_axi_arvalid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (o_read_done !== 1'b0 || m_axi_arvalid !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_after: done=%b arvalid=%b required 0 0",
               o_read_done, m_axi_arvalid);
    end
  endtask

  initial begin
    rst           = 1'b1;
    i_start       = 1'b0;
    i_src_addr    = '0;
    i_total_len   = '0;
    i_fifo_count  = '0;
    m_axi_arready = 1'b0;
    m_axi_rdata   = '0;
    m_axi_rresp   = 2'b00;
    m_axi_rlast   = 1'b0;
    m_axi_rvalid  = 1'b0;
    test_reset;
    test_single;
    test_two_bursts;
    test_4k_boundary;
    test_fifo_space;
    test_rresp_error;
    test_rlast_early;
    test_reset_mid;
    test_zero_len;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
